// File: rtl/axi_bram_fifo_stream_slave_if.sv
// rtl/axi_bram_fifo_stream_slave_if.sv - stream and AXI4-Lite signal bundle for the stream-slave FIFO
interface axi_bram_fifo_stream_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tlast;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr;
  logic [2:0]              s00_axi_awprot;
  logic                    s00_axi_awvalid;
  logic                    s00_axi_awready;
  logic [DATA_WIDTH-1:0]   s00_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb;
  logic                    s00_axi_wvalid;
  logic                    s00_axi_wready;
  logic [1:0]              s00_axi_bresp;
  logic                    s00_axi_bvalid;
  logic                    s00_axi_bready;
  logic [ADDR_WIDTH-1:0]   s00_axi_araddr;
  logic [2:0]              s00_axi_arprot;
  logic                    s00_axi_arvalid;
  logic                    s00_axi_arready;
  logic [DATA_WIDTH-1:0]   s00_axi_rdata;
  logic [1:0]              s00_axi_rresp;
  logic                    s00_axi_rvalid;
  logic                    s00_axi_rready;

  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

// File: rtl/axi_bram_fifo_stream_slave.sv
// rtl/axi_bram_fifo_stream_slave.sv - AXI4-Stream receive FIFO drained through AXI4-Lite registers
module axi_bram_fifo_stream_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_ADDR_WIDTH      = 10
) (
  input logic                         s00_axi_aclk,
  input logic                         s00_axi_aresetn,
  axi_bram_fifo_stream_slave_if.slave bus
);
  localparam int DW    = C_S00_AXI_DATA_WIDTH;
  localparam int AW    = C_S00_AXI_ADDR_WIDTH;
  localparam int CW    = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic       {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_e;

  // FIFO storage: data plus tlast in the wide array, tlast mirrored so the
  // head flag can be read combinationally without touching the BRAM port
  logic [DW:0]                mem_q      [DEPTH];
  logic                       last_mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [CW-1:0]              count_q, count_d;

  logic enable_q, underflow_q, flush_q;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    rsel_q;
  logic [DW:0]   bram_q;
  logic          dvalid_q;
  logic [DW-1:0] samp_q, rdata_q;

  logic          empty, full, head_last, push, pop, uf_set;
  logic          aw_hs, ar_hs, ctrl_wr, clr_uf;
  logic [1:0]    wsel, rsel_in;
  logic [DW-1:0] status_word, count_word, ctrl_word;

  assign wsel    = bus.s00_axi_awaddr[AW-1:AW-2];
  assign rsel_in = bus.s00_axi_araddr[AW-1:AW-2];

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head_last = !empty && last_mem_q[rptr_q];

  assign status_word = {{(DW-4){1'b0}}, head_last, underflow_q, full, empty};
  assign count_word  = {{(DW-CW){1'b0}}, count_q};
  assign ctrl_word   = {{(DW-1){1'b0}}, enable_q};

  // The flush cycle blocks the stream so no word lands while pointers clear
  assign bus.s_axis_tready   = enable_q && !full && !flush_q;
  assign push                = bus.s_axis_tvalid && bus.s_axis_tready;

  assign bus.s00_axi_awready = awready_q;
  assign bus.s00_axi_wready  = awready_q;
  assign bus.s00_axi_bvalid  = bvalid_q;
  assign bus.s00_axi_bresp   = 2'b00;
  assign bus.s00_axi_arready = arready_q;
  assign bus.s00_axi_rvalid  = rvalid_q;
  assign bus.s00_axi_rdata   = rdata_q;
  assign bus.s00_axi_rresp   = 2'b00;

  // Handshake decode, pop/underflow decode, count update and FSM next state
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    count_d   = count_q;
    aw_hs     = awready_q && bus.s00_axi_awvalid && bus.s00_axi_wvalid;
    ar_hs     = arready_q && bus.s00_axi_arvalid;
    ctrl_wr   = aw_hs && (wsel == REG_CTRL) && bus.s00_axi_wstrb[0];
    clr_uf    = ctrl_wr && bus.s00_axi_wdata[2];
    pop       = (r_state_q == R_FETCH) && (rsel_q == REG_DATA) && !empty;
    uf_set    = (r_state_q == R_FETCH) && (rsel_q == REG_DATA) && empty;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    unique case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_RESP;
      W_RESP:  if (bvalid_q && bus.s00_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_RESP;
      R_RESP:  if (rvalid_q && bus.s00_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // FSM state registers
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Write channel: one-cycle ready pulse, delayed response, CTRL side effects
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      enable_q    <= 1'b0;
      flush_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      awready_q <= (w_state_q == W_IDLE) && bus.s00_axi_awvalid &&
                   bus.s00_axi_wvalid && !awready_q;
      if (w_state_q == W_RESP && !bvalid_q) begin
        bvalid_q <= 1'b1;
      end else if (bvalid_q && bus.s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ctrl_wr) begin
        enable_q <= bus.s00_axi_wdata[0];
      end
      flush_q <= ctrl_wr && bus.s00_axi_wdata[1];
      // a fresh underflow outranks a clear arriving in the same cycle
      if (uf_set) begin
        underflow_q <= 1'b1;
      end else if (clr_uf) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Read channel: latch the register select, sample in FETCH, register rdata in RESP
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      arready_q <= 1'b0;
      rsel_q    <= REG_DATA;
      dvalid_q  <= 1'b0;
      samp_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      arready_q <= (r_state_q == R_IDLE) && bus.s00_axi_arvalid && !arready_q;
      if (ar_hs) begin
        rsel_q <= rsel_in;
      end
      if (r_state_q == R_FETCH) begin
        dvalid_q <= !empty;
        unique case (rsel_q)
          REG_STATUS: samp_q <= status_word;
          REG_COUNT:  samp_q <= count_word;
          REG_CTRL:   samp_q <= ctrl_word;
          default:    samp_q <= '0;
        endcase
      end
      if (r_state_q == R_RESP && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (rsel_q == REG_DATA) ? (dvalid_q ? bram_q[DW-1:0] : '0) : samp_q;
      end else if (rvalid_q && bus.s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // BRAM read port, clocked only while a register read is being fetched
  always_ff @(posedge s00_axi_aclk) begin
    if (r_state_q == R_FETCH) begin
      bram_q <= mem_q[rptr_q];
    end
  end

  // BRAM write port
  always_ff @(posedge s00_axi_aclk) begin
    if (push) begin
      mem_q[wptr_q]      <= {bus.s_axis_tlast, bus.s_axis_tdata};
      last_mem_q[wptr_q] <= bus.s_axis_tlast;
    end
  end

  // Pointers wrap naturally at the depth; flush and reset discard all contents
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || flush_q) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.s00_axi_awprot, bus.s00_axi_arprot,
                         bus.s00_axi_awaddr[AW-3:0], bus.s00_axi_araddr[AW-3:0],
                         bus.s00_axi_wstrb[DW/8-1:1], bus.s00_axi_wdata[DW-1:3],
                         bram_q[DW]};
endmodule

// File: tb/tb_axi_bram_fifo_stream_slave.sv
// tb/tb_axi_bram_fifo_stream_slave.sv - self-checking bench for the stream-slave FIFO
module tb_axi_bram_fifo_stream_slave;
  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_COUNT  = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'hC;

  typedef enum {OP_WR, OP_RD, OP_PUSH} op_e;
  typedef struct {
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        use_sb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int failed = 0;
  logic [31:0] sb[$];
  vec_t vecs[$];

  axi_bram_fifo_stream_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  axi_bram_fifo_stream_slave #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4),
    .FIFO_ADDR_WIDTH(10)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got no handshake within bound, expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(op_e op, logic [3:0] a, logic [31:0] d, logic [3:0] s,
                              logic l, logic u, logic [31:0] e, string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.strb = s;
    v.last = l; v.use_sb = u; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    bus.s00_axi_awaddr = a;
    bus.s00_axi_wdata = d;
    bus.s00_axi_wstrb = s;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_awready && n < 50) begin tick(); n++; end
    if (!bus.s00_axi_awready) begin
      bus.s00_axi_awvalid = 1'b0;
      bus.s00_axi_wvalid = 1'b0;
      timeout_fail("awready");
      return;
    end
    check("wready_with_awready", 32'(bus.s00_axi_wready), 32'd1);
    tick();
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid = 1'b0;
    n = 0;
    while (!bus.s00_axi_bvalid && n < 50) begin tick(); n++; end
    check("b_latency", 32'(n), 32'd1);
    check("bresp", 32'(bus.s00_axi_bresp), 32'd0);
    bus.s00_axi_bready = 1'b1;
    tick();
    bus.s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    d = '0;
    bus.s00_axi_araddr = a;
    bus.s00_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_arready && n < 50) begin tick(); n++; end
    if (!bus.s00_axi_arready) begin
      bus.s00_axi_arvalid = 1'b0;
      timeout_fail("arready");
      return;
    end
    tick();
    bus.s00_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s00_axi_rvalid && n < 50) begin tick(); n++; end
    check("r_latency", 32'(n), 32'd2);
    check("rresp", 32'(bus.s00_axi_rresp), 32'd0);
    d = bus.s00_axi_rdata;
    bus.s00_axi_rready = 1'b1;
    tick();
    bus.s00_axi_rready = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l, output logic ok);
    int n;
    bus.s_axis_tdata = d;
    bus.s_axis_tlast = l;
    bus.s_axis_tvalid = 1'b1;
    n = 0;
    while (!bus.s_axis_tready && n < 200) begin tick(); n++; end
    ok = bus.s_axis_tready;
    if (!ok) begin
      bus.s_axis_tvalid = 1'b0;
      timeout_fail("s_axis_tready");
      return;
    end
    tick();
    sb.push_back(d);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic check_pop(input string name, input logic [31:0] act);
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: got 0x%08h, expected no word (scoreboard empty)", name, act);
    end else begin
      check(name, act, sb.pop_front());
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    logic ok;
    int n;
    int got;
    int it;

    bus.s_axis_tdata = '0;  bus.s_axis_tlast = 1'b0;  bus.s_axis_tvalid = 1'b0;
    bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata = '0;  bus.s00_axi_wstrb = '0;  bus.s00_axi_wvalid = 1'b0;
    bus.s00_axi_bready = 1'b0;
    bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready = 1'b0;

    repeat (3) tick();
    check("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_awready", 32'(bus.s00_axi_awready), 32'd0);
    check("rst_wready", 32'(bus.s00_axi_wready), 32'd0);
    check("rst_arready", 32'(bus.s00_axi_arready), 32'd0);
    check("rst_bvalid", 32'(bus.s00_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.s00_axi_rvalid), 32'd0);
    check("rst_rdata", bus.s00_axi_rdata, 32'd0);
    check("rst_bresp", 32'(bus.s00_axi_bresp), 32'd0);
    check("rst_rresp", 32'(bus.s00_axi_rresp), 32'd0);
    resetn = 1'b1;
    tick();

    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h1, "status_after_reset"));
    vecs.push_back(mk(OP_RD,   A_COUNT,  0, 0, 0, 0, 32'h0, "count_after_reset"));
    vecs.push_back(mk(OP_RD,   A_CTRL,   0, 0, 0, 0, 32'h0, "ctrl_after_reset"));
    vecs.push_back(mk(OP_WR,   A_CTRL,   32'h1, 4'hF, 0, 0, 0, "enable"));
    vecs.push_back(mk(OP_PUSH, 0, 32'h0101FFFF, 0, 0, 0, 0, "push0"));
    vecs.push_back(mk(OP_PUSH, 0, 32'habcd0001, 0, 0, 0, 0, "push1"));
    vecs.push_back(mk(OP_PUSH, 0, 32'hdead0011, 0, 0, 0, 0, "push2"));
    vecs.push_back(mk(OP_PUSH, 0, 32'hbeef0011, 0, 1, 0, 0, "push3"));
    vecs.push_back(mk(OP_RD,   A_COUNT,  0, 0, 0, 0, 32'h4, "count_4"));
    vecs.push_back(mk(OP_RD,   A_DATA,   0, 0, 0, 1, 0, "data0"));
    vecs.push_back(mk(OP_RD,   A_DATA,   0, 0, 0, 1, 0, "data1"));
    vecs.push_back(mk(OP_RD,   A_DATA,   0, 0, 0, 1, 0, "data2"));
    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h8, "status_head_last"));
    vecs.push_back(mk(OP_RD,   A_DATA,   0, 0, 0, 1, 0, "data3"));
    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h1, "status_empty"));
    vecs.push_back(mk(OP_RD,   A_CTRL,   0, 0, 0, 0, 32'h1, "ctrl_enable_rb"));
    vecs.push_back(mk(OP_WR,   A_STATUS, 32'hFFFF, 4'hF, 0, 0, 0, "wr_ro_status"));
    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h1, "status_ro_ignored"));
    vecs.push_back(mk(OP_RD,   A_DATA,   0, 0, 0, 0, 32'h0, "data_underflow"));
    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h5, "status_underflow"));
    vecs.push_back(mk(OP_WR,   A_CTRL,   32'h5, 4'hF, 0, 0, 0, "clr_uf"));
    vecs.push_back(mk(OP_RD,   A_STATUS, 0, 0, 0, 0, 32'h1, "status_uf_cleared"));
    vecs.push_back(mk(OP_RD,   A_CTRL,   0, 0, 0, 0, 32'h1, "ctrl_after_clr_uf"));
    vecs.push_back(mk(OP_WR,   A_CTRL,   32'h0, 4'hE, 0, 0, 0, "ctrl_no_byte0"));
    vecs.push_back(mk(OP_RD,   A_CTRL,   0, 0, 0, 0, 32'h1, "ctrl_strb_ignored"));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        OP_PUSH: push_word(vecs[i].data, vecs[i].last, ok);
        default: begin
          axi_read(vecs[i].addr, rd);
          if (vecs[i].use_sb) check_pop(vecs[i].name, rd);
          else                check(vecs[i].name, rd, vecs[i].exp);
        end
      endcase
    end

    // stream disabled: tvalid held, nothing accepted
    axi_write(A_CTRL, 32'h0, 4'hF);
    bus.s_axis_tdata = 32'h77770000;
    bus.s_axis_tvalid = 1'b1;
    repeat (4) tick();
    check("tready_disabled", 32'(bus.s_axis_tready), 32'd0);
    axi_read(A_COUNT, rd);
    check("count_disabled", rd, 32'd0);
    bus.s_axis_tvalid = 1'b0;
    axi_write(A_CTRL, 32'h1, 4'hF);
    check("tready_enabled", 32'(bus.s_axis_tready), 32'd1);

    // pop and push landing on the same edge with a single word stored
    push_word(32'hA1A10001, 1'b0, ok);
    bus.s00_axi_araddr = A_DATA;
    bus.s00_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_arready && n < 50) begin tick(); n++; end
    check("pp_arready", 32'(bus.s00_axi_arready), 32'd1);
    tick();
    bus.s00_axi_arvalid = 1'b0;
    bus.s_axis_tdata = 32'hB2B20002;
    bus.s_axis_tlast = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    check("pp_tready", 32'(bus.s_axis_tready), 32'd1);
    tick();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    sb.push_back(32'hB2B20002);
    n = 0;
    while (!bus.s00_axi_rvalid && n < 50) begin tick(); n++; end
    check_pop("pp_old_head", bus.s00_axi_rdata);
    bus.s00_axi_rready = 1'b1;
    tick();
    bus.s00_axi_rready = 1'b0;
    axi_read(A_COUNT, rd);  check("pp_count", rd, 32'd1);
    axi_read(A_STATUS, rd); check("pp_status", rd, 32'h8);
    axi_read(A_DATA, rd);   check_pop("pp_new_head", rd);

    // fill to full depth
    for (int i = 0; i < 1024; i++) begin
      push_word(32'h10000000 + i, 1'b0, ok);
      if (!ok) break;
    end
    check("tready_full", 32'(bus.s_axis_tready), 32'd0);
    axi_read(A_COUNT, rd);  check("count_full", rd, 32'd1024);
    axi_read(A_STATUS, rd); check("status_full", rd, 32'h2);
    axi_read(A_DATA, rd);   check_pop("data_from_full", rd);
    axi_read(A_STATUS, rd); check("status_after_full_pop", rd, 32'h0);
    check("tready_after_full_pop", 32'(bus.s_axis_tready), 32'd1);

    // flush from nearly full, then from COUNT=10
    axi_write(A_CTRL, 32'h3, 4'hF);
    sb.delete();
    axi_read(A_COUNT, rd);  check("count_flush_big", rd, 32'd0);
    for (int i = 0; i < 10; i++) push_word(32'h20000000 + i, 1'b0, ok);
    axi_read(A_COUNT, rd);  check("count_10", rd, 32'd10);
    axi_write(A_CTRL, 32'h3, 4'hF);
    sb.delete();
    axi_read(A_COUNT, rd);  check("count_flush", rd, 32'd0);
    axi_read(A_STATUS, rd); check("status_flush", rd, 32'h1);
    axi_read(A_CTRL, rd);   check("ctrl_after_flush", rd, 32'h1);

    // continuous stream against back-to-back DATA reads across the pointer wrap
    got = 0;
    it = 0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          push_word(32'h5A000000 + i, 1'(i & 1), ok);
          if (!ok) break;
        end
      end
      begin
        while (got < 2000 && it < 8000) begin
          axi_read(A_DATA, rd2);
          if (rd2 != 32'd0) begin
            check_pop("stream_word", rd2);
            got++;
          end
          it++;
        end
      end
    join
    check("stream_words_received", 32'(got), 32'd2000);
    check("stream_sb_drained", 32'(sb.size()), 32'd0);
    axi_write(A_CTRL, 32'h5, 4'hF);
    axi_read(A_STATUS, rd); check("status_after_stream", rd, 32'h1);

    // reset in the middle of a read response
    for (int i = 0; i < 3; i++) push_word(32'h30000000 + i, 1'b0, ok);
    bus.s00_axi_araddr = A_DATA;
    bus.s00_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s00_axi_arready && n < 50) begin tick(); n++; end
    tick();
    bus.s00_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s00_axi_rvalid && n < 50) begin tick(); n++; end
    check("midrd_rvalid_up", 32'(bus.s00_axi_rvalid), 32'd1);
    resetn = 1'b0;
    tick();
    check("midrd_rvalid_drop", 32'(bus.s00_axi_rvalid), 32'd0);
    check("midrd_rdata_zero", bus.s00_axi_rdata, 32'd0);
    tick();
    resetn = 1'b1;
    sb.delete();
    tick();
    check("post_reset_tready", 32'(bus.s_axis_tready), 32'd0);
    axi_read(A_COUNT, rd);  check("post_reset_count", rd, 32'd0);
    axi_read(A_STATUS, rd); check("post_reset_status", rd, 32'h1);
    axi_read(A_CTRL, rd);   check("post_reset_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
